food_pos_gen: RTL and testbench

- Parametrised pseudo-random position generator for snake food placement.
- Runs two free-running maximal-length Fibonacci LFSRs (X, Y) and samples them on request.
- Rejects candidates outside the playfield or occupied by the snake (occupancy-RAM query), retrying until MAX_TRIES is exhausted.
- Sits between the game-control FSM (req/done) and the occupancy RAM (query port).

---
 rtl/food_pos_pkg.sv | 17 +
 rtl/food_pos_gen_lfsr_core.sv | 35 +++
 rtl/food_pos_gen.sv | 181 ++++++++++++++++++
 tb/tb_food_pos_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/food_pos_pkg.sv
// Shared types and default constants for the food position generator.
// Default taps give maximal-length 10-bit sequences.
package food_pos_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    QUERY,
    WAIT
  } state_e;

  localparam logic [9:0] DEF_X_TAPS = 10'h240;
  localparam logic [9:0] DEF_Y_TAPS = 10'h204;
  localparam logic [9:0] DEF_X_SEED = 10'h3FF;
  localparam logic [9:0] DEF_Y_SEED = 10'h155;

endpackage

// File: rtl/food_pos_gen_lfsr_core.sv
// Free-running Fibonacci LFSR with synchronous load.
// A zero load value is replaced by SEED so the register never locks up.
module lfsr_core #(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = '1,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    if (load) begin
      q_d = (load_val == '0) ? SEED : load_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/food_pos_gen.sv
// Picks a random free in-field cell for snake food, retrying on
// out-of-range or occupied candidates up to MAX_TRIES times.
module food_pos_gen
  import food_pos_pkg::*;
#(
  parameter int                LFSR_W    = 10,
  parameter logic [LFSR_W-1:0] X_TAPS    = LFSR_W'(DEF_X_TAPS),
  parameter logic [LFSR_W-1:0] Y_TAPS    = LFSR_W'(DEF_Y_TAPS),
  parameter logic [LFSR_W-1:0] X_SEED    = LFSR_W'(DEF_X_SEED),
  parameter logic [LFSR_W-1:0] Y_SEED    = LFSR_W'(DEF_Y_SEED),
  parameter int                COORD_W   = 7,
  parameter int                X_LIMIT   = 80,
  parameter int                Y_LIMIT   = 60,
  parameter int                MAX_TRIES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed,
  input  logic               req,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               occ_req,
  output logic [COORD_W-1:0] occ_x,
  output logic [COORD_W-1:0] occ_y,
  input  logic               occ_hit,
  output logic [LFSR_W-1:0]  lfsr_x,
  output logic [LFSR_W-1:0]  lfsr_y
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [COORD_W:0] X_LIM = (COORD_W + 1)'(X_LIMIT);
  localparam logic [COORD_W:0] Y_LIM = (COORD_W + 1)'(Y_LIMIT);

  lfsr_core #(
    .WIDTH (LFSR_W),
    .TAPS  (X_TAPS),
    .SEED  (X_SEED)
  ) u_lfsr_x (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_load),
    .load_val (seed),
    .q        (lfsr_x)
  );

  lfsr_core #(
    .WIDTH (LFSR_W),
    .TAPS  (Y_TAPS),
    .SEED  (Y_SEED)
  ) u_lfsr_y (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_load),
    .load_val (seed ^ Y_SEED),
    .q        (lfsr_y)
  );

  state_e             state_q, state_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic               occ_req_q, occ_req_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] pos_y_q, pos_y_d;
  logic [COORD_W-1:0] occ_x_q, occ_x_d;
  logic [COORD_W-1:0] occ_y_q, occ_y_d;

  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               in_range;
  logic               reject;
  logic [COORD_W-1:0] rej_x;
  logic [COORD_W-1:0] rej_y;

  assign cand_x   = lfsr_x[COORD_W-1:0];
  assign cand_y   = lfsr_y[COORD_W-1:0];
  assign in_range = ({1'b0, cand_x} < X_LIM) && ({1'b0, cand_y} < Y_LIM);

  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    occ_req_d = 1'b0;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    occ_x_d   = occ_x_q;
    occ_y_d   = occ_y_q;
    reject    = 1'b0;
    rej_x     = cand_x;
    rej_y     = cand_y;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SAMPLE;
          tries_d = '0;
        end
      end
      SAMPLE: begin
        if (in_range) begin
          state_d   = QUERY;
          occ_req_d = 1'b1;
          occ_x_d   = cand_x;
          occ_y_d   = cand_y;
        end else begin
          reject = 1'b1;
        end
      end
      QUERY: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!occ_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
          pos_x_d = occ_x_q;
          pos_y_d = occ_y_q;
        end else begin
          reject = 1'b1;
          rej_x  = occ_x_q;
          rej_y  = occ_y_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Out of retries: report the last candidate even if unusable.
    if (reject) begin
      if (tries_q == LAST_TRY) begin
        state_d = IDLE;
        done_d  = 1'b1;
        fail_d  = 1'b1;
        pos_x_d = rej_x;
        pos_y_d = rej_y;
      end else begin
        state_d = SAMPLE;
        tries_d = tries_q + TRY_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tries_q   <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      occ_req_q <= 1'b0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      occ_x_q   <= '0;
      occ_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      occ_req_q <= occ_req_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      occ_x_q   <= occ_x_d;
      occ_y_q   <= occ_y_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign fail    = fail_q;
  assign occ_req = occ_req_q;
  assign occ_x   = occ_x_q;
  assign occ_y   = occ_y_q;
  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;

endmodule

// File: tb/tb_food_pos_gen.sv
// Directed bench for food_pos_gen: LFSR sequence, latency,
// retry/fail behaviour, seed loading and mid-operation reset.
module tb_food_pos_gen;

  localparam logic [9:0] XT = 10'h240;
  localparam logic [9:0] YT = 10'h204;
  localparam logic [9:0] XS = 10'h3FF;
  localparam logic [9:0] YS = 10'h155;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seed_load = 1'b0;
  logic [9:0] seed = '0;
  logic       req = 1'b0;
  logic       req8 = 1'b0;
  logic       occ_hit = 1'b0;

  logic       busy, done, fail, occ_req;
  logic [6:0] pos_x, pos_y, occ_x, occ_y;
  logic [9:0] lfsr_x, lfsr_y;

  logic       busy8, done8, fail8, occ_req8;
  logic [6:0] pos_x8, pos_y8, occ_x8, occ_y8;
  logic [9:0] lfsr_x8, lfsr_y8;

  int total = 0;
  int bad = 0;
  logic [6:0] last_px, last_py;

  always #5 clk = ~clk;

  food_pos_gen u_dut (
    .clk (clk), .rst_n (rst_n),
    .seed_load (seed_load), .seed (seed),
    .req (req), .busy (busy), .done (done), .fail (fail),
    .pos_x (pos_x), .pos_y (pos_y),
    .occ_req (occ_req), .occ_x (occ_x), .occ_y (occ_y),
    .occ_hit (occ_hit),
    .lfsr_x (lfsr_x), .lfsr_y (lfsr_y)
  );

  food_pos_gen #(.X_LIMIT (8)) u_dut8 (
    .clk (clk), .rst_n (rst_n),
    .seed_load (seed_load), .seed (seed),
    .req (req8), .busy (busy8), .done (done8), .fail (fail8),
    .pos_x (pos_x8), .pos_y (pos_y8),
    .occ_req (occ_req8), .occ_x (occ_x8), .occ_y (occ_y8),
    .occ_hit (1'b0),
    .lfsr_x (lfsr_x8), .lfsr_y (lfsr_y8)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] step(input logic [9:0] s,
                                      input logic [9:0] taps);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 10; i++)
      if (taps[i]) fb = fb ^ s[i];
    return {s[8:0], fb};
  endfunction

  // Reference LFSR pair, shared by both DUTs (same seeds and loads).
  logic [9:0] mx, my;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx <= XS;
      my <= YS;
    end else if (seed_load) begin
      mx <= (seed == 10'h0) ? XS : seed;
      my <= ((seed ^ YS) == 10'h0) ? YS : (seed ^ YS);
    end else begin
      mx <= step(mx, XT);
      my <= step(my, YT);
    end
  end

  // Transaction predictor: offsets are cycles after the req cycle.
  task automatic predict(input logic [9:0] x0, input logic [9:0] y0,
                         input logic hit, input int xlim,
                         output int nd, output int nq, output int fq,
                         output logic fl,
                         output logic [6:0] px, output logic [6:0] py);
    logic [9:0] x, y;
    int d, tries;
    bit fin;
    x = step(x0, XT); y = step(y0, YT);
    d = 1; tries = 0; nq = 0; fq = -1; fin = 0;
    fl = 0; nd = 0; px = '0; py = '0;
    while (!fin) begin
      px = x[6:0]; py = y[6:0];
      if (int'(px) < xlim && int'(py) < 60) begin
        nq++;
        if (fq < 0) fq = d + 1;
        if (!hit) begin
          nd = d + 3; fin = 1;
        end else if (tries == 15) begin
          nd = d + 3; fl = 1; fin = 1;
        end else begin
          tries++;
          repeat (3) begin x = step(x, XT); y = step(y, YT); end
          d += 3;
        end
      end else if (tries == 15) begin
        nd = d + 1; fl = 1; fin = 1;
      end else begin
        tries++;
        x = step(x, XT); y = step(y, YT);
        d += 1;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_req(input bit sel, input logic hit_v,
                         input bit poke);
    int nd, nq, fq, k, seen_q, first_q;
    logic fl;
    logic [6:0] px, py;
    bit got;
    occ_hit = hit_v;
    predict(mx, my, hit_v, sel ? 8 : 80, nd, nq, fq, fl, px, py);
    if (sel) req8 = 1'b1; else req = 1'b1;
    seen_q = 0; first_q = -1; got = 0; k = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      req = 1'b0; req8 = 1'b0;
      if (poke && k == 2) req = 1'b1;
      if (k == 1) chk("busy_k1", sel ? busy8 : busy, 1);
      if (sel ? occ_req8 : occ_req) begin
        seen_q++;
        if (first_q < 0) first_q = k;
      end
      if (sel ? done8 : done) begin
        got = 1;
        chk("done_cycle", k, nd);
        chk("fail", sel ? fail8 : fail, fl);
        chk("pos_x", sel ? pos_x8 : pos_x, px);
        chk("pos_y", sel ? pos_y8 : pos_y, py);
        chk("busy_done", sel ? busy8 : busy, 0);
        chk("occ_cnt", seen_q, nq);
        chk("occ_first", first_q, fq);
        if (sel && !fl) begin
          chk("x8_range", int'(pos_x8) < 8, 1);
          chk("y8_range", int'(pos_y8) < 60, 1);
        end
        last_px = px; last_py = py;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  logic [9:0] hx [3] = '{10'h3FE, 10'h3FC, 10'h3F8};

  initial begin
    int ret, zeros, dn, k;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_lfsr_x", lfsr_x, 10'h3FF);
    chk("rst_lfsr_y", lfsr_y, 10'h155);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_occ_req", occ_req, 0);
    chk("rst_pos_x", pos_x, 0);
    chk("rst_pos_y", pos_y, 0);
    chk("rst_occ_x", occ_x, 0);
    chk("rst_occ_y", occ_y, 0);
    rst_n = 1'b1;

    ret = -1; zeros = 0;
    for (int n = 1; n <= 1023; n++) begin
      @(negedge clk);
      if (n <= 3) chk("seq_x", lfsr_x, hx[n-1]);
      if (n == 1) chk("seq_y", lfsr_y, 10'h2AB);
      if (lfsr_x == 10'h0 || lfsr_y == 10'h0) zeros++;
      if (ret < 0 && lfsr_x == XS && lfsr_y == YS) ret = n;
    end
    chk("period", ret, 1023);
    chk("no_zero", zeros, 0);

    run_req(0, 1'b0, 0);
    run_req(0, 1'b0, 0);
    run_req(0, 1'b1, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("fail_pulse", fail, 0);
    chk("busy_after", busy, 0);
    chk("pos_hold_x", pos_x, last_px);
    chk("pos_hold_y", pos_y, last_py);
    occ_hit = 1'b0;

    seed = 10'h000; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    chk("seed0_x", lfsr_x, 10'h3FF);
    chk("seed0_y", lfsr_y, 10'h155);
    seed = 10'h001; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    chk("seed1_x", lfsr_x, 10'h001);
    chk("seed1_y", lfsr_y, 10'h154);
    chk("seed1_x8", lfsr_x8, 10'h001);
    @(negedge clk);
    chk("seed1_step_x", lfsr_x, 10'h002);
    chk("seed1_step_y", lfsr_y, 10'h2A9);
    seed = 10'h155; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    chk("seedy0_x", lfsr_x, 10'h155);
    chk("seedy0_y", lfsr_y, 10'h155);

    repeat (4) run_req(1, 1'b0, 0);
    @(negedge clk);

    occ_hit = 1'b0; seen = 0; k = 0;
    while (!seen && k < 300) begin
      if (!busy) req = 1'b1;
      @(negedge clk);
      k++;
      req = 1'b0;
      if (occ_req) seen = 1;
    end
    chk("occ_seen", seen, 1);
    @(negedge clk);
    chk("wait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_occ_req", occ_req, 0);
    chk("mid_pos_x", pos_x, 0);
    chk("mid_occ_x", occ_x, 0);
    chk("mid_lfsr_x", lfsr_x, 10'h3FF);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (done) dn++;
    chk("mid_no_done", dn, 0);
    run_req(0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
